// File: rtl/audio_framer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_pkg : shared types for the audio framer                        |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package audio_pkg;

  localparam int SAMPLE_WIDTH = 8;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } framer_state_t;

endpackage
`default_nettype wire

// File: rtl/framer_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | framer_ram : simple dual-port RAM, one write port, one registered    |
// |              read port with enable (BRAM-inferable)                  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module framer_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // No reset on the array or read register so the tools can map this to block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/audio_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_framer : buffers the sample stream into overlapping frames and |
// |                replays them over a valid/ready stream                |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module audio_framer #(
  parameter int FRAME_LEN    = 256,
  parameter int HOP          = 128,
  parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           audio_valid_in,
  input  logic signed [SAMPLE_WIDTH-1:0] audio_in,
  output logic signed [SAMPLE_WIDTH-1:0] frame_data_out,
  output logic                           frame_valid_out,
  input  logic                           frame_ready_in,
  output logic                           frame_last_out,
  output logic [$clog2(FRAME_LEN)-1:0]   frame_index_out,
  output logic                           overrun_out,
  output logic [15:0]                    frame_count_out
);

  import audio_pkg::framer_state_t;
  import audio_pkg::IDLE;
  import audio_pkg::PRIME;
  import audio_pkg::STREAM;

  localparam int c_DEPTH = 2 * FRAME_LEN;
  localparam int c_AW    = $clog2(c_DEPTH);
  localparam int c_IW    = $clog2(FRAME_LEN);
  localparam int c_CW    = c_IW + 1;

  localparam logic [c_CW-1:0] c_FRAME_LEN = c_CW'(FRAME_LEN);
  localparam logic [c_CW-1:0] c_WARM_LAST = c_CW'(FRAME_LEN - 1);
  localparam logic [c_CW-1:0] c_HOP_LAST  = c_CW'(HOP - 1);
  localparam logic [c_AW-1:0] c_BACK      = c_AW'(FRAME_LEN - 1);
  localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(FRAME_LEN - 1);

  framer_state_t r_state;

  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_total_cnt;
  logic [c_CW-1:0] r_hop_cnt;
  logic [c_CW-1:0] r_rd_cnt;

  // RAM read register acts as the skid entry in front of the output register.
  logic            r_q_valid;
  logic [c_IW-1:0] r_q_index;

  logic [SAMPLE_WIDTH-1:0] w_rd_data;
  logic [SAMPLE_WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_last;
  logic [c_IW-1:0]         r_index;
  logic                    r_overrun;
  logic [15:0]             r_count;

  logic            w_trigger;
  logic            w_handshake;
  logic            w_last_hs;
  logic            w_accept;
  logic            w_out_load;
  logic            w_rd_en;
  logic [c_AW-1:0] w_start_ptr;

  assign w_trigger   = audio_valid_in &&
                       ((r_total_cnt == c_WARM_LAST) ||
                        ((r_total_cnt == c_FRAME_LEN) && (r_hop_cnt == c_HOP_LAST)));
  assign w_handshake = r_valid && frame_ready_in;
  assign w_last_hs   = w_handshake && r_last;
  assign w_accept    = w_trigger && ((r_state == IDLE) || ((r_state == STREAM) && w_last_hs));
  assign w_out_load  = r_q_valid && (!r_valid || frame_ready_in);
  assign w_rd_en     = (r_state == PRIME) ||
                       ((r_state == STREAM) && (r_rd_cnt != c_FRAME_LEN) &&
                        (!r_q_valid || w_out_load));
  assign w_start_ptr = r_wr_ptr - c_BACK;

  framer_ram #(
    .DEPTH (c_DEPTH),
    .WIDTH (SAMPLE_WIDTH)
  ) u_ram (
    .clk     (clk_in),
    .i_we    (audio_valid_in),
    .i_waddr (r_wr_ptr),
    .i_wdata (audio_in),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_total_cnt <= '0;
      r_hop_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_q_valid   <= 1'b0;
      r_q_index   <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_index     <= '0;
      r_overrun   <= 1'b0;
      r_count     <= '0;
    end else begin
      if (audio_valid_in) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_total_cnt != c_FRAME_LEN) begin
          r_total_cnt <= r_total_cnt + 1'b1;
        end
      end

      if (w_trigger) begin
        r_hop_cnt <= '0;
      end else if (audio_valid_in && (r_total_cnt == c_FRAME_LEN)) begin
        r_hop_cnt <= r_hop_cnt + 1'b1;
      end

      r_overrun <= w_trigger && !w_accept;

      if (w_rd_en) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_cnt  <= r_rd_cnt + 1'b1;
        r_q_valid <= 1'b1;
        r_q_index <= r_rd_cnt[c_IW-1:0];
      end else if (w_out_load) begin
        r_q_valid <= 1'b0;
      end

      if (w_out_load) begin
        r_valid <= 1'b1;
        r_data  <= w_rd_data;
        r_index <= r_q_index;
        r_last  <= (r_q_index == c_LAST_IDX);
      end else if (w_handshake) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= PRIME;
          end
        end
        PRIME: begin
          r_state <= STREAM;
        end
        STREAM: begin
          if (w_last_hs) begin
            r_count <= r_count + 1'b1;
            r_state <= w_accept ? PRIME : IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // A new frame restarts the read side at the oldest sample of its window.
      if (w_accept) begin
        r_rd_ptr <= w_start_ptr;
        r_rd_cnt <= '0;
      end
    end
  end

  assign frame_data_out  = r_data;
  assign frame_valid_out = r_valid;
  assign frame_last_out  = r_last;
  assign frame_index_out = r_index;
  assign overrun_out     = r_overrun;
  assign frame_count_out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_audio_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_audio_framer : scoreboard bench for audio_framer                  |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_audio_framer;

  localparam int FL = 256;
  localparam int HP = 128;
  localparam int P  = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        audio_valid_in;
  logic [7:0]  audio_in;
  logic [7:0]  frame_data_out;
  logic        frame_valid_out;
  logic        frame_ready_in;
  logic        frame_last_out;
  logic [7:0]  frame_index_out;
  logic        overrun_out;
  logic [15:0] frame_count_out;

  always #5 clk_in = ~clk_in;

  audio_framer #(
    .FRAME_LEN    (FL),
    .HOP          (HP),
    .SAMPLE_WIDTH (8)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .audio_valid_in  (audio_valid_in),
    .audio_in        (audio_in),
    .frame_data_out  (frame_data_out),
    .frame_valid_out (frame_valid_out),
    .frame_ready_in  (frame_ready_in),
    .frame_last_out  (frame_last_out),
    .frame_index_out (frame_index_out),
    .overrun_out     (overrun_out),
    .frame_count_out (frame_count_out)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] idx;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] hist[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         beats     = 0;
  int         overruns  = 0;
  int         exp_count = 0;
  int         mode      = 0;
  int         n_glob    = 0;
  int         drop_k    = 768;
  logic [7:0] salt      = 8'hA5;

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  logic       prev_stall = 1'b0;
  logic       chk_end    = 1'b0;
  logic [7:0] pd, pi;
  logic       pl;
  always @(negedge clk_in) begin
    if (!rst_in) begin
      exp_q.delete();
      exp_count  = 0;
      prev_stall = 1'b0;
      chk_end    = 1'b0;
    end else begin
      if (chk_end) begin
        check("frame_count", frame_count_out, exp_count);
        check("gap_after_last", frame_valid_out, 0);
        chk_end = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", frame_valid_out, 1);
        check("stall_data", frame_data_out, pd);
        check("stall_index", frame_index_out, pi);
        check("stall_last", frame_last_out, pl);
      end
      if (overrun_out) overruns++;
      if (frame_valid_out && frame_ready_in) begin
        beat_t e;
        beats++;
        check("beat_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_data", frame_data_out, e.d);
          check("beat_index", frame_index_out, e.idx);
          check("beat_last", frame_last_out, e.last);
          if (e.last) begin
            exp_count++;
            chk_end = 1'b1;
          end
        end
      end
      prev_stall = frame_valid_out && !frame_ready_in;
      pd = frame_data_out;
      pi = frame_index_out;
      pl = frame_last_out;
    end
  end

  task automatic cycle();
    case (mode)
      0:       frame_ready_in = 1'b1;
      1:       frame_ready_in = 1'($urandom_range(0, 1));
      2:       frame_ready_in = 1'b0;
      default: frame_ready_in = !(frame_valid_out && frame_last_out);
    endcase
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_sample(input logic [7:0] v, input bit expect_drop);
    int k;
    bit trig;
    hist.push_back(v);
    k    = hist.size();
    trig = (k >= FL) && (((k - FL) % HP) == 0);
    if (trig && !expect_drop) begin
      for (int i = 0; i < FL; i++)
        exp_q.push_back('{d: hist[k-FL+i], idx: 8'(i), last: (i == FL-1)});
    end
    audio_in       = v;
    audio_valid_in = 1'b1;
    cycle();
    audio_valid_in = 1'b0;
    if (trig) begin
      check("overrun_at_trigger", overrun_out, expect_drop ? 1 : 0);
      if (!expect_drop) check("valid_t0", frame_valid_out, 0);
    end
    for (int g = 1; g < P; g++) begin
      cycle();
      if (trig && g == 1) begin
        if (expect_drop) check("overrun_one_cycle", overrun_out, 0);
        else             check("valid_t1", frame_valid_out, 0);
      end
      if (trig && !expect_drop && g == 2) check("valid_t2", frame_valid_out, 1);
    end
  endtask

  task automatic feed(input int count);
    for (int j = 0; j < count; j++) begin
      logic [7:0] v;
      v = (n_glob < 512) ? 8'(n_glob) : (8'(n_glob) ^ salt);
      write_sample(v, (hist.size() + 1) == drop_k);
      n_glob++;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", frame_valid_out, 0);
    check("rst_last", frame_last_out, 0);
    check("rst_index", frame_index_out, 0);
    check("rst_data", frame_data_out, 0);
    check("rst_overrun", overrun_out, 0);
    check("rst_count", frame_count_out, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst_in         = 1'b0;
    audio_valid_in = 1'b0;
    audio_in       = 8'd0;
    frame_ready_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_outputs();
    rst_in = 1'b1;
    cycle();

    // Warm-up, first frame and hop frame with ready held high.
    feed(255);
    check("warmup_no_beats", beats, 0);
    feed(128);
    check("count_after_f1", frame_count_out, 1);
    feed(128);
    check("count_after_f2", frame_count_out, 2);

    // Random backpressure on frame 3.
    mode = 1;
    feed(128);
    check("count_after_f3", frame_count_out, 3);

    // Frame 4 stalled across the next trigger, which must be dropped.
    mode = 2;
    feed(129);
    mode = 0;
    feed(127);
    check("count_after_f4", frame_count_out, 4);
    check("overrun_total", overruns, 1);

    // Frame 5 parks on its last beat until the next trigger write.
    mode = 3;
    feed(128);
    check("park_valid", frame_valid_out, 1);
    check("park_last", frame_last_out, 1);
    check("park_index", frame_index_out, 255);
    mode = 0;
    feed(1);
    check("coincident_no_overrun", overruns, 1);

    // Reset in the middle of frame 6.
    for (int c = 0; c < 400; c++) begin
      if (frame_valid_out && frame_index_out == 8'd100) break;
      cycle();
    end
    check("beat100_index", frame_index_out, 100);
    rst_in = 1'b0;
    #1;
    check_reset_outputs();
    salt = 8'h3C;
    hist.delete();
    cycle();
    cycle();
    rst_in = 1'b1;
    cycle();
    snap = beats;
    feed(255);
    check("post_reset_no_beats", beats - snap, 0);
    feed(1);
    for (int c = 0; c < 2000; c++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    check("drain_post_reset", exp_q.size(), 0);
    cycle();
    check("count_post_reset", frame_count_out, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
